// File: rtl/im2_scheduler.sv
// im2_scheduler: layer sequencer in front of the im2 address generator.
// Walks n / patch_i / patch_j / k_grp, issuing one en_im2 burst per K-group
// and waiting for im2's done before stepping to the next group.
module im2_scheduler #(
  parameter int DATA_WIDTH_map = 8,
  parameter int CHUNK_K        = 8,
  parameter int Pack           = 4,
  parameter int MAX_X1         = 5,
  parameter int MAX_X2         = 5,
  parameter int MAX_X3         = 32,
  parameter int MAX_Y1         = 32,
  parameter int MAX_Y2         = 32,
  parameter int MAX_N          = 16,
  localparam int X1W = $clog2(MAX_X1) + 1,
  localparam int X2W = $clog2(MAX_X2) + 1,
  localparam int X3W = $clog2(MAX_X3) + 1,
  localparam int Y1W = $clog2(MAX_Y1) + 1,
  localparam int Y2W = $clog2(MAX_Y2) + 1,
  localparam int NW  = $clog2(MAX_N) + 1,
  localparam int KGW = $clog2(MAX_X1 * MAX_X2 * MAX_X3) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           hold,
  input  logic [X1W-1:0] X1,
  input  logic [X2W-1:0] X2,
  input  logic [X3W-1:0] X3,
  input  logic [Y1W-1:0] Y1,
  input  logic [Y2W-1:0] Y2,
  input  logic [2:0]     STRIDE,
  input  logic [NW-1:0]  N_out,
  input  logic           im2_done,
  output logic           en_im2,
  output logic [Y2W-1:0] patch_i,
  output logic [Y1W-1:0] patch_j,
  output logic [NW-1:0]  n,
  output logic [KGW-1:0] k_grp,
  output logic           grp_first,
  output logic           grp_last,
  output logic           pix_done,
  output logic           busy,
  output logic           all_done,
  output logic           cfg_err
);

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, GAP, HOLD, DONE} state_e;

  localparam logic [15:0] GRP   = 16'(CHUNK_K * Pack);
  localparam logic [15:0] BURST = 16'(DATA_WIDTH_map);

  state_e         state_q;
  logic [15:0]    rem_w_q, rem_h_q, rem_k_q;
  logic [15:0]    ow_q, oh_q, ng_q, stride_q, nout_q, burst_cnt_q;
  logic [Y2W-1:0] pi_q;
  logic [Y1W-1:0] pj_q;
  logic [NW-1:0]  n_q;
  logic [KGW-1:0] kg_q;
  logic           en_q, first_q, last_q, pix_q, all_q, busy_q, err_q;

  // Geometry widened so every sum, difference and product is exact.
  logic [15:0] x1_w, x2_w, x3_w, y1_w, y2_w, s_w;
  assign x1_w = 16'(X1);
  assign x2_w = 16'(X2);
  assign x3_w = 16'(X3);
  assign y1_w = 16'(Y1);
  assign y2_w = 16'(Y2);
  assign s_w  = 16'(STRIDE);

  logic cfg_bad;
  assign cfg_bad = !(x1_w == 16'd1 || x1_w == 16'd3 || x1_w == 16'd5) ||
                   (x1_w != x2_w) || (x1_w > y1_w) || (x2_w > y2_w) ||
                   (s_w == 16'd0) || (N_out == '0) || (X3 == '0);

  // Wrap conditions: equality against (count-1).
  logic           kg_last, pj_last, pi_last, n_last, div_done;
  logic [KGW-1:0] kg_nxt;
  assign kg_last  = (16'(kg_q) == ng_q - 16'd1);
  assign pj_last  = (16'(pj_q) == ow_q - 16'd1);
  assign pi_last  = (16'(pi_q) == oh_q - 16'd1);
  assign n_last   = (16'(n_q)  == nout_q - 16'd1);
  assign kg_nxt   = kg_last ? '0 : kg_q + KGW'(1);
  assign div_done = (rem_w_q < stride_q) && (rem_h_q < stride_q) && (rem_k_q == 16'd0);

  // Layer FSM: dividers, index walk and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rem_w_q     <= '0;
      rem_h_q     <= '0;
      rem_k_q     <= '0;
      ow_q        <= '0;
      oh_q        <= '0;
      ng_q        <= '0;
      stride_q    <= '0;
      nout_q      <= '0;
      burst_cnt_q <= '0;
      pi_q        <= '0;
      pj_q        <= '0;
      n_q         <= '0;
      kg_q        <= '0;
      en_q        <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      pix_q       <= 1'b0;
      all_q       <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every branch below reads
      // the pre-edge values; the pulse defaults here are overridden later.
      pix_q <= 1'b0;
      all_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              err_q <= 1'b1;
            end else begin
              state_q  <= CALC;
              busy_q   <= 1'b1;
              // Pre-biasing by one stride makes the subtraction count the
              // full output size, so each divider ends after exactly q steps.
              rem_w_q  <= y1_w - x1_w + s_w;
              rem_h_q  <= y2_w - x2_w + s_w;
              rem_k_q  <= x1_w * x2_w * x3_w;
              ow_q     <= '0;
              oh_q     <= '0;
              ng_q     <= '0;
              stride_q <= s_w;
              nout_q   <= 16'(N_out);
              pi_q     <= '0;
              pj_q     <= '0;
              n_q      <= '0;
              kg_q     <= '0;
            end
          end
        end
        CALC: begin
          if (rem_w_q >= stride_q) begin
            rem_w_q <= rem_w_q - stride_q;
            ow_q    <= ow_q + 16'd1;
          end
          if (rem_h_q >= stride_q) begin
            rem_h_q <= rem_h_q - stride_q;
            oh_q    <= oh_q + 16'd1;
          end
          if (rem_k_q != 16'd0) begin
            rem_k_q <= (rem_k_q > GRP) ? rem_k_q - GRP : 16'd0;
            ng_q    <= ng_q + 16'd1;
          end
          if (div_done) begin
            state_q     <= ISSUE;
            en_q        <= 1'b1;
            burst_cnt_q <= '0;
            first_q     <= 1'b1;
            last_q      <= (ng_q == 16'd1);
          end
        end
        ISSUE: begin
          if (burst_cnt_q != BURST) burst_cnt_q <= burst_cnt_q + 16'd1;
          // A done seen before a full burst can only be stale; wait it out.
          if (im2_done && burst_cnt_q == BURST) begin
            state_q <= GAP;
            en_q    <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
          end
        end
        GAP: begin
          pix_q <= kg_last;
          kg_q  <= kg_nxt;
          if (kg_last) begin
            if (pj_last) begin
              pj_q <= '0;
              if (pi_last) begin
                pi_q <= '0;
                n_q  <= n_last ? '0 : n_q + NW'(1);
              end else begin
                pi_q <= pi_q + Y2W'(1);
              end
            end else begin
              pj_q <= pj_q + Y1W'(1);
            end
          end
          if (kg_last && pj_last && pi_last && n_last) begin
            state_q <= DONE;
          end else if (hold) begin
            state_q <= HOLD;
          end else begin
            state_q     <= ISSUE;
            en_q        <= 1'b1;
            burst_cnt_q <= '0;
            first_q     <= (kg_nxt == '0);
            last_q      <= (16'(kg_nxt) == ng_q - 16'd1);
          end
        end
        HOLD: begin
          if (!hold) begin
            state_q     <= ISSUE;
            en_q        <= 1'b1;
            burst_cnt_q <= '0;
            first_q     <= (kg_q == '0);
            last_q      <= kg_last;
          end
        end
        DONE: begin
          all_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign en_im2    = en_q;
  assign patch_i   = pi_q;
  assign patch_j   = pj_q;
  assign n         = n_q;
  assign k_grp     = kg_q;
  assign grp_first = first_q;
  assign grp_last  = last_q;
  assign pix_done  = pix_q;
  assign busy      = busy_q;
  assign all_done  = all_q;
  assign cfg_err   = err_q;

endmodule

// File: doc/im2_scheduler.md
# im2_scheduler

Sequencer directly upstream of the `im2` address generator. For one convolution layer, it walks output channel `n`, output row `patch_i`, output column `patch_j` and K-group `k_grp`. It issues one `en_im2` burst per group and waits for the generator's `done` before advancing. Side-band flags tell the downstream accumulator when a patch starts and ends.

## Interface
Parameters:
- DATA_WIDTH_map, 8, cycles per im2 burst (k_cnt range); must match the im2 instance
- CHUNK_K, 8, k_cnt slots per group
- Pack, 4, lanes per slot; one group covers CHUNK_K*Pack kernel elements
- MAX_X1 / MAX_X2 / MAX_X3, 5 / 5 / 32, kernel width / height / input channels
- MAX_Y1 / MAX_Y2, 32 / 32, map width / height
- MAX_N, 16, output channels

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  one-cycle layer start; sampled only in IDLE
- hold  in  1  downstream stall; checked only between groups
- X1, X2, X3, Y1, Y2  in  $clog2(MAX_*)+1 each  layer geometry; stable while busy
- STRIDE  in  3  stride, 1..7
- N_out  in  $clog2(MAX_N)+1  number of output channels
- im2_done  in  1  `done` from im2
- en_im2  out  1  burst enable to im2
- patch_i, patch_j, n, k_grp  out  im2 port widths  current indices
- grp_first  out  1  high with en_im2 when k_grp==0
- grp_last  out  1  high with en_im2 when k_grp==num_grp-1
- pix_done  out  1  one-cycle pulse after the last group of a patch
- busy  out  1  high from start acceptance to all_done
- all_done  out  1  one-cycle pulse when the layer completes
- cfg_err  out  1  one-cycle pulse when a config is rejected

## Operation
- **States:** IDLE, CALC, ISSUE, GAP, HOLD, DONE.
- **IDLE → CALC** on `start`. The config is invalid if any of these hold: `X1` not in {1,3,5}; `X1`≠`X2`; `X1`>`Y1`; `X2`>`Y2`; `STRIDE`==0; `N_out`==0; `X3`==0. An invalid config pulses `cfg_err` and the block stays in IDLE; `busy` stays 0.
- **CALC** runs three repeated-subtraction dividers in parallel:
  - out_w = (Y1−X1)/STRIDE + 1
  - out_h = (Y2−X2)/STRIDE + 1
  - num_grp = ceil(X1*X2*X3 / (CHUNK_K*Pack))
  - Each divider subtracts once per cycle; the state exits the cycle after all three finish.
  - All indices clear to 0. Next state is ISSUE.
- **ISSUE:** `en_im2`=1; indices are held. Stay until `im2_done`=1, then go to GAP.
- **GAP:** `en_im2`=0 for exactly one cycle; this clears im2's sticky `done` and `k_cnt`. Advance the indices with `k_grp` innermost, then `patch_j`, `patch_i`, then `n`; each wraps to 0 and carries outward.
  - When the finished group was the last group of a patch, pulse `pix_done`.
  - When every index wraps, go to DONE.
  - Otherwise go to HOLD if `hold`=1, else to ISSUE.
- **HOLD:** stay while `hold`=1; go to ISSUE the cycle after it is sampled 0.
- **DONE:** pulse `all_done`, drop `busy`, return to IDLE.
- **Arithmetic:** all products and sums are computed at ≥16 bits, so no truncation is possible for the MAX_* values. Index compares are equality against (count−1).

## Timing
- **Reset values:** all outputs are 0 and the state is IDLE. An asynchronous assert mid-burst drops `en_im2` immediately; no flag pulses afterwards.
- **Start:** `busy` rises the cycle after `start` is accepted. `start` is ignored while busy.
- **CALC latency:** max(out_w, out_h, num_grp) + 1 cycles.
- **Steady-state cost:** DATA_WIDTH_map + 2 cycles per group. This is ISSUE for DATA_WIDTH_map+1 cycles (im2's `done` registers one cycle after `k_cnt` reaches DATA_WIDTH_map−1), plus one GAP cycle.
- **Flag timing:** `grp_first` and `grp_last` change only at ISSUE entry. `pix_done` and `all_done` are registered, one cycle each. `pix_done` for the final patch coincides with the DONE state; `all_done` follows one cycle later.
- **num_grp==1:** `grp_first` and `grp_last` are both high for the whole burst.
- **hold:** asserting `hold` during ISSUE has no effect until GAP. A `hold` that is already low in GAP costs no extra cycle.
- **im2_done in the wrong state:** ignored when high outside ISSUE.

## Test plan
- **Basic layer:** Y1=Y2=8, X1=X2=3, X3=1, STRIDE=1, N_out=1. Expect out_w=out_h=6, num_grp=1, 36 bursts of 9 `en_im2` cycles, 36 `pix_done` pulses, and `all_done` exactly 36*10 cycles after CALC exits.
- **Multi-group:** X1=X2=5, X3=3 (K=75). Expect num_grp=3; `k_grp` sequence 0,1,2 per patch; `grp_first` only at 0; `grp_last` only at 2.
- **Stride and carries:** Y1=Y2=11, X1=3, STRIDE=2, N_out=2. Expect out_w=out_h=5; `patch_j` wraps 4→0 with `patch_i`+1; `n` goes 0→1 after patch (4,4); 50 `pix_done` pulses total.
- **Hold:** `hold`=1 for 5 cycles starting mid-burst. The burst completes unchanged; the next ISSUE starts 6 cycles after GAP; indices are unchanged through HOLD.
- **Bad configs:** X1=4, or STRIDE=0, or X1=5 with Y1=4. Each gives a `cfg_err` pulse one cycle after `start`, and `busy`, `en_im2` stay 0.
- **Reset mid-operation:** assert `rst`=0 during group 10. All outputs go to 0 asynchronously. After release and a new `start`, the sequence restarts at indices (0,0,0,0).
